// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game: debounce defaults and the
// idle level of the active-low push-buttons.
package tow_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;

  typedef logic [$clog2(DEBOUNCE_DEFAULT)-1:0] db_cnt_t;

  localparam logic KEY_RELEASED = 1'b1;

endpackage : tow_pkg

// File: rtl/key_channel.sv
// One push-button path: input synchronizer, debounce filter, press edge and
// the pending move request that is held until a game tick consumes it.
module key_channel
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic key_n,
  output logic req,
  output logic held,
  output logic overrun_hit
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   held_r;
  logic                   held_next_s;
  logic                   held_d_r;
  logic                   pend_r;
  logic                   pend_next_s;
  logic                   raw_pressed_s;
  logic                   press_s;
  logic                   overrun_hit_s;

  // Synchronizer chain, preset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{KEY_RELEASED}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key_n};
    end
  end

  assign raw_pressed_s = ~sync_r[SYNC_STAGES-1];

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_next_s  = {CNT_W{1'b0}};
    held_next_s = held_r;
    if (raw_pressed_s == held_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s  = {CNT_W{1'b0}};
      held_next_s = ~held_r;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Debounce counter, accepted level and its one-cycle-delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      held_r   <= 1'b0;
      held_d_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_next_s;
      held_r   <= held_next_s;
      held_d_r <= held_r;
    end
  end

  assign press_s = held_r & ~held_d_r;

  // A fresh press beats a consume on the same edge; a press onto a waiting request is lost.
  always_comb begin
    pend_next_s   = pend_r;
    overrun_hit_s = 1'b0;
    if (press_s) begin
      pend_next_s   = 1'b1;
      overrun_hit_s = pend_r & ~ce;
    end else if (ce && pend_r) begin
      pend_next_s = 1'b0;
    end else begin
      pend_next_s = pend_r;
    end
  end

  // Pending request register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
    end
  end

  assign req         = pend_r;
  assign held        = held_r;
  assign overrun_hit = overrun_hit_s;

endmodule : key_channel

// File: rtl/key_press_conditioner.sv
// Front end for the tug-of-war light chain: two independent key channels
// turning raw active-low buttons into one L/R request per press.
module key_press_conditioner
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic CE,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic L,
  output logic R,
  output logic L_held,
  output logic R_held,
  output logic overrun
);

  logic l_hit_s;
  logic r_hit_s;
  logic overrun_r;

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_left (
    .clk         (clk),
    .reset       (reset),
    .ce          (CE),
    .key_n       (key_l_n),
    .req         (L),
    .held        (L_held),
    .overrun_hit (l_hit_s)
  );

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_right (
    .clk         (clk),
    .reset       (reset),
    .ce          (CE),
    .key_n       (key_r_n),
    .req         (R),
    .held        (R_held),
    .overrun_hit (r_hit_s)
  );

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r | l_hit_s | r_hit_s;
    end
  end

  assign overrun = overrun_r;

endmodule : key_press_conditioner
